// File: rtl/neuron_mac_engine.sv
// Perceptron register bank plus sequential MAC engine: Offset + sum(Coef[i]*X[i]), one tap per cycle.
// Optional macro RELU_EN clamps negative results to zero (Classe still reports the pre-activation sign).
module neuron_mac_engine #(
  parameter int DATA_W = 16,
  parameter int N_COEF = 20,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [DATA_W-1:0]   DataIn,
  input  logic [N_COEF+1:0]   EnableRegister,
  input  logic                EnableStart,
  output logic                Busy,
  output logic                Done,
  output logic [DATA_W-1:0]   Result,
  output logic                Classe
);

  localparam int K_W  = (N_COEF > 1) ? $clog2(N_COEF) : 1;
  localparam int EN_W = N_COEF + 2;
  localparam logic [EN_W-1:0] EN_ONE = EN_W'(1);
  localparam logic [K_W-1:0]  K_LAST = K_W'(N_COEF - 1);
  localparam logic [K_W-1:0]  K_ONE  = K_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [DATA_W-1:0] r_coef [N_COEF];
  logic signed [DATA_W-1:0] r_x    [N_COEF];
  logic signed [DATA_W-1:0] r_offset;
  logic signed [ACC_W-1:0]  r_acc;
  logic [K_W-1:0]           r_k;
  logic                     r_start_d;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_classe;
  logic [DATA_W-1:0]        r_result;

  logic                       w_start_edge;
  logic                       w_wr_ok;
  logic                       w_load;
  logic                       w_mac;
  logic                       w_final;
  logic [EN_W-1:0]            w_en_sel;
  logic signed [DATA_W-1:0]   w_coef_k;
  logic signed [DATA_W-1:0]   w_x_k;
  logic signed [2*DATA_W-1:0] w_coef_ext;
  logic signed [2*DATA_W-1:0] w_x_ext;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_offset_acc;
  logic signed [ACC_W-1:0]    w_s;
  logic [DATA_W-1:0]          w_sat;
  logic [DATA_W-1:0]          w_act;

  assign w_start_edge = EnableStart & ~r_start_d;
  assign w_wr_ok      = (r_state == ST_IDLE);
  // x & -x isolates the lowest set enable, so an illegal multi-hot write touches one register only
  assign w_en_sel     = EnableRegister & (~EnableRegister + EN_ONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_COEF; i++) begin
        r_coef[i] <= '0;
        r_x[i]    <= '0;
      end
      r_offset <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < N_COEF; i++) begin
        if (w_en_sel[i]) r_coef[i] <= DataIn;
      end
      if (w_en_sel[N_COEF]) r_offset <= DataIn;
      if (w_en_sel[N_COEF+1]) begin
        r_x[0] <= DataIn;
        for (int i = 1; i < N_COEF; i++) begin
          r_x[i] <= r_x[i-1];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_mac        = 1'b0;
    w_final      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_state_next = ST_MAC;
          w_load       = 1'b1;
        end
      end
      ST_MAC: begin
        w_mac = 1'b1;
        if (r_k == K_LAST) w_state_next = ST_FINAL;
      end
      ST_FINAL: begin
        w_final      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_coef_k     = r_coef[r_k];
  assign w_x_k        = r_x[r_k];
  assign w_coef_ext   = {{DATA_W{w_coef_k[DATA_W-1]}}, w_coef_k};
  assign w_x_ext      = {{DATA_W{w_x_k[DATA_W-1]}}, w_x_k};
  assign w_prod       = w_coef_ext * w_x_ext;
  assign w_prod_ext   = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  // Offset is aligned to the product's 2*FRAC binary point
  assign w_offset_acc = {{(ACC_W-DATA_W-FRAC){r_offset[DATA_W-1]}}, r_offset, {FRAC{1'b0}}};
  assign w_s          = r_acc >>> FRAC;

  always_comb begin
    w_sat = w_s[DATA_W-1:0];
    if (w_s > SAT_MAX)      w_sat = SAT_MAX[DATA_W-1:0];
    else if (w_s < SAT_MIN) w_sat = SAT_MIN[DATA_W-1:0];
`ifdef RELU_EN
    w_act = w_s[ACC_W-1] ? '0 : w_sat;
`else
    w_act = w_sat;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_acc     <= '0;
      r_k       <= '0;
      r_start_d <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_classe  <= 1'b0;
    end else begin
      r_start_d <= EnableStart;
      r_done    <= w_final;
      if (w_load) begin
        r_acc  <= w_offset_acc;
        r_k    <= '0;
        r_busy <= 1'b1;
      end
      if (w_mac) begin
        r_acc <= r_acc + w_prod_ext;
        r_k   <= r_k + K_ONE;
      end
      if (w_final) begin
        r_result <= w_act;
        r_classe <= ~r_acc[ACC_W-1];
        r_busy   <= 1'b0;
      end
    end
  end

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Result = r_result;
  assign Classe = r_classe;

endmodule

// File: tb/tb_neuron_mac_engine.sv
// Self-checking bench for neuron_mac_engine: timeline model checked every cycle plus literal results.
module tb_neuron_mac_engine;

  localparam int DW = 16;
  localparam int NC = 20;
`ifdef RELU_EN
  localparam logic [15:0] EXP_NEG_SAT = 16'h0000;
  localparam logic [15:0] EXP_MINUS1  = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG_SAT = 16'h8000;
  localparam logic [15:0] EXP_MINUS1  = 16'hFF00;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic [DW-1:0] DataIn;
  logic [NC+1:0] EnableRegister;
  logic          EnableStart;
  logic          Busy;
  logic          Done;
  logic [DW-1:0] Result;
  logic          Classe;

  int n_assert = 0;
  int n_fail   = 0;

  neuron_mac_engine dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .DataIn         (DataIn),
    .EnableRegister (EnableRegister),
    .EnableStart    (EnableStart),
    .Busy           (Busy),
    .Done           (Done),
    .Result         (Result),
    .Classe         (Classe)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic signed [15:0] m_coef [NC];
  logic signed [15:0] m_x    [NC];
  logic signed [15:0] m_offset;
  logic signed [15:0] m_off_old;
  logic        m_valid = 1'b0;
  logic        m_busy, m_done, m_classe, m_prev_start, m_pend_cls;
  logic [15:0] m_result, m_pend_res;
  int          m_rem;
  int          m_sel;

  function automatic void model_eval(input logic signed [15:0] off,
                                     output logic [15:0] res, output logic cls);
    longint acc;
    longint s;
    acc = longint'(off) * 256;
    for (int i = 0; i < NC; i++) acc += longint'(m_coef[i]) * longint'(m_x[i]);
    s = acc >>> 8;
    if (s > 32767)       res = 16'h7FFF;
    else if (s < -32768) res = 16'h8000;
    else                 res = 16'(s);
`ifdef RELU_EN
    if (s < 0) res = 16'h0000;
`endif
    cls = (acc >= 0);
  endfunction

  // Compare outputs against the model, then advance the model with the inputs the next edge will sample.
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("cyc_busy",   32'(Busy),   32'(m_busy));
      chk("cyc_done",   32'(Done),   32'(m_done));
      chk("cyc_result", 32'(Result), 32'(m_result));
      chk("cyc_classe", 32'(Classe), 32'(m_classe));
    end
    if (Reset === 1'b1) begin
      for (int i = 0; i < NC; i++) begin
        m_coef[i] = '0;
        m_x[i]    = '0;
      end
      m_offset = '0; m_busy = 0; m_done = 0; m_result = '0; m_classe = 0;
      m_prev_start = 0; m_rem = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = 0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1; m_result = m_pend_res; m_classe = m_pend_cls;
        end
      end else begin
        m_off_old = m_offset;
        m_sel = -1;
        for (int i = 0; i < NC + 2; i++) if (EnableRegister[i] && m_sel < 0) m_sel = i;
        if (m_sel >= 0 && m_sel < NC) m_coef[m_sel] = DataIn;
        else if (m_sel == NC) m_offset = DataIn;
        else if (m_sel == NC + 1) begin
          for (int j = NC - 1; j > 0; j--) m_x[j] = m_x[j-1];
          m_x[0] = DataIn;
        end
        if (EnableStart && !m_prev_start) begin
          model_eval(m_off_old, m_pend_res, m_pend_cls);
          m_busy = 1;
          m_rem  = NC + 1;
        end
      end
      m_prev_start = EnableStart;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int idx, input logic [15:0] d);
    EnableRegister = '0;
    EnableRegister[idx] = 1'b1;
    DataIn = d;
    @(posedge Clk); #1;
    EnableRegister = '0;
  endtask

  task automatic load_bank(input logic [15:0] c, input logic [15:0] xv, input logic [15:0] off);
    for (int i = 0; i < NC; i++) wr(i, c);
    wr(NC, off);
    for (int i = 0; i < NC; i++) wr(NC + 1, xv);
  endtask

  task automatic start_run();
    EnableStart = 1'b1;
    @(posedge Clk); #1;
    EnableStart = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) begin
        cyc = c;
        break;
      end
    end
    if (cyc == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL done_timeout: got no Done expected Done within 40 cycles");
    end
  endtask

  task automatic run_and_check(input string nm, input logic [15:0] exp_res, input logic exp_cls);
    int cyc;
    start_run();
    wait_done(cyc);
    chk({nm, "_latency"}, 32'(cyc), 32'd21);
    chk({nm, "_result"},  32'(Result), 32'(exp_res));
    chk({nm, "_classe"},  32'(Classe), 32'(exp_cls));
    chk({nm, "_model"},   32'(m_result), 32'(exp_res));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n_done;
    int n_busy;
    Reset = 1'b1; DataIn = '0; EnableRegister = '0; EnableStart = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("reset_busy",   32'(Busy),   32'd0);
    chk("reset_done",   32'(Done),   32'd0);
    chk("reset_result", 32'(Result), 32'd0);
    chk("reset_classe", 32'(Classe), 32'd0);

    // 1: unit weights, unit inputs -> 20.0
    load_bank(16'h0100, 16'h0100, 16'h0000);
    run_and_check("t1", 16'h1400, 1'b1);
    run_and_check("t1_b2b", 16'h1400, 1'b1);

    // 2: positive and negative saturation
    load_bank(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_and_check("t2_pos", 16'h7FFF, 1'b1);
    for (int i = 0; i < NC; i++) wr(i, 16'h8000);
    run_and_check("t2_neg", EXP_NEG_SAT, 1'b0);

    // 3: offset only, -1.0
    load_bank(16'h0000, 16'h7FFF, 16'hFF00);
    run_and_check("t3", EXP_MINUS1, 1'b0);

    // 4: held start level with a re-pulse while busy
    load_bank(16'h0100, 16'h0100, 16'h0000);
    n_done = 0; n_busy = 0;
    EnableStart = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) n_done++;
      if (Busy === 1'b1) n_busy++;
      if (i == 9)  EnableStart = 1'b0;
      if (i == 10) EnableStart = 1'b1;
    end
    EnableStart = 1'b0;
    chk("t4_done_count", 32'(n_done), 32'd1);
    chk("t4_busy_cycles", 32'(n_busy), 32'd21);
    chk("t4_result", 32'(Result), 32'h1400);

    // 5: writes during a run are dropped; X = 0x10,0x20..0x140, sum = 0x0D20
    for (int i = 1; i <= NC; i++) wr(NC + 1, 16'(16 * i));
    start_run();
    wr(3, 16'h0200);
    wr(NC + 1, 16'h7000);
    wait_done(cyc);
    chk("t5_result", 32'(Result), 32'h0D20);
    run_and_check("t5_rerun", 16'h0D20, 1'b1);

    // 6: reset mid-MAC clears everything
    start_run();
    repeat (7) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("t6_busy",   32'(Busy),   32'd0);
    chk("t6_result", 32'(Result), 32'd0);
    chk("t6_done",   32'(Done),   32'd0);
    run_and_check("t6_zero", 16'h0000, 1'b1);

    // 7: multi-hot enable -> only the lowest (Coef[0]) is written
    wr(NC + 1, 16'h0100);
    EnableRegister = '0;
    EnableRegister[0] = 1'b1; EnableRegister[NC] = 1'b1; EnableRegister[NC+1] = 1'b1;
    DataIn = 16'h0300;
    @(posedge Clk); #1;
    EnableRegister = '0;
    run_and_check("t7", 16'h0300, 1'b1);

    repeat (2) @(posedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
